// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared FSM state encoding and default operand width for the
//            sequential restoring divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/trial_sub.sv
// ============================================================================
// Module   : trial_sub
// Purpose  : Combinational trial subtractor a - b computed as a + ~b + 1;
//            borrow is the inverted carry-out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] w_sum;

    assign w_sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign diff   = w_sum[W-1:0];
    assign borrow = ~w_sum[W];

endmodule

`default_nettype wire

// File: rtl/seq_divider_8.sv
// ============================================================================
// Module   : seq_divider_8
// Purpose  : Unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_divider_8
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_upper;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_unused_diff_msb;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_dvd;
    logic             w_load;

    // Upper half of {partial remainder, dividend} after the left shift.
    assign w_upper = {rem_q, dvd_q[WIDTH-1]};

    trial_sub #(
        .W (WIDTH + 1)
    ) u_trial_sub (
        .a      (w_upper),
        .b      ({1'b0, dsr_q}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    assign w_unused_diff_msb = w_diff[WIDTH];
    assign w_step_rem        = w_borrow ? w_upper[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_step_dvd        = {dvd_q[WIDTH-2:0], ~w_borrow};

    // A zero divisor parks one cycle in IDLE with pend_q set, then reports.
    assign w_load = start && (((state_q == IDLE) && !pend_q) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        pend_d  = pend_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    quo_d   = '1;
                    rmd_d   = dvd_q;
                    dbz_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = DONE;
                end
            end
            RUN: begin
                rem_d = w_step_rem;
                dvd_d = w_step_dvd;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = w_step_dvd;
                    rmd_d   = w_step_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_load) begin
            dvd_d = dividend;
            dsr_d = divisor;
            rem_d = '0;
            if (divisor != '0) begin
                cnt_d   = CW'(WIDTH);
                state_d = RUN;
            end else begin
                cnt_d   = '0;
                pend_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            pend_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            pend_q  <= pend_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || pend_q;
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: doc/seq_divider_8.md
SEQ_DIVIDER_8 -- requirements
Module: seq_divider_8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand, quotient and remainder bit width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: division request, sampled at a rising clk edge.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator, sampled with start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: result of the last completed division.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: remainder of the last completed division.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: set when the last completed division had divisor 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE or DONE with start=1 at edge k and divisor!=0: latch operands, clear partial remainder, load the iteration counter with WIDTH, go to RUN, and assert busy from edge k.
REQ-014 RUN SHALL perform one restoring step per edge: shift {partial remainder, dividend register} left by 1; trial-subtract divisor from the upper half; on no borrow, keep the difference and shift in quotient bit 1; otherwise keep the shifted value and shift in 0; decrement the counter.
REQ-015 The final step SHALL occur at edge k+WIDTH, which SHALL register quotient, remainder and div_by_zero=0, set done=1 and busy=0, and enter DONE.
REQ-016 DONE SHALL last exactly one cycle; at the next edge the FSM SHALL return to IDLE with done=0, unless start=1, in which case REQ-013 applies (back-to-back operation).
REQ-017 For divisor=0 at a start edge k, the FSM SHALL skip RUN and enter DONE at edge k+1 with quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-018 start SHALL be ignored while in RUN; dividend and divisor changes during RUN SHALL have no effect.
REQ-019 quotient, remainder and div_by_zero SHALL hold their values until the next completion and SHALL NOT change during RUN.
REQ-020 The trial subtraction SHALL be WIDTH+1 bits wide, computed as a + ~b + 1, with borrow = NOT carry-out; no overflow is possible.
REQ-021 The result SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor!=0.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and clear busy, done, quotient, remainder, div_by_zero, the counter and all working registers.
REQ-023 Reset asserted mid-RUN SHALL abort the division with no done pulse; the first start after rst_n deasserts SHALL behave as in REQ-013.

Structure
REQ-024 The package div_pkg SHALL hold the FSM state enumeration and the default WIDTH constant.
REQ-025 The trial subtractor SHALL be the separate combinational sub-module trial_sub (inputs a, b; outputs diff and borrow); all state SHALL live in seq_divider_8.

Verification
REQ-026 Divide 200/7 -> done 8 cycles after the start edge, quotient=28, remainder=4, div_by_zero=0.
REQ-027 Divide 255/1 -> quotient=255, remainder=0; then 5/9 issued back-to-back from DONE -> quotient=0, remainder=5, with no IDLE cycle between the two operations.
REQ-028 Divide 100/0 -> done 1 cycle after start, quotient=255, remainder=100, div_by_zero=1.
REQ-029 Pulse start with new operands 3 cycles into 200/7 -> ignored; result remains 28 r 4.
REQ-030 Assert rst_n=0 at cycle 4 of a division -> all outputs 0 at once, no done pulse; a following 17/5 gives 3 r 2.
REQ-031 Random sweep of 10,000 operand pairs -> REQ-021 holds, with the done latency as specified for every pair.
